// File: rtl/gpr_file_if.sv
// gpr_file_if: write-back write port, decode read ports and busy scoreboard signals of the GPR file.
interface gpr_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5
);
  logic                  i_wbu_gpr_wr_en;
  logic [GPRS_WIDTH-1:0] i_wbu_gpr_wr_id;
  logic [DATA_WIDTH-1:0] i_wbu_gpr_wr_data;
  logic [GPRS_WIDTH-1:0] i_idu_rs1_id;
  logic [GPRS_WIDTH-1:0] i_idu_rs2_id;
  logic [DATA_WIDTH-1:0] o_gpr_rs1_data;
  logic [DATA_WIDTH-1:0] o_gpr_rs2_data;
  logic                  i_idu_busy_set_en;
  logic [GPRS_WIDTH-1:0] i_idu_busy_set_id;
  logic                  i_flush;
  logic                  o_gpr_rs1_busy;
  logic                  o_gpr_rs2_busy;
  logic [GPRS_WIDTH:0]   o_gpr_busy_cnt;
  modport master (
    output i_wbu_gpr_wr_en, i_wbu_gpr_wr_id, i_wbu_gpr_wr_data, i_idu_rs1_id, i_idu_rs2_id,
           i_idu_busy_set_en, i_idu_busy_set_id, i_flush,
    input  o_gpr_rs1_data, o_gpr_rs2_data, o_gpr_rs1_busy, o_gpr_rs2_busy, o_gpr_busy_cnt
  );
  modport slave (
    input  i_wbu_gpr_wr_en, i_wbu_gpr_wr_id, i_wbu_gpr_wr_data, i_idu_rs1_id, i_idu_rs2_id,
           i_idu_busy_set_en, i_idu_busy_set_id, i_flush,
    output o_gpr_rs1_data, o_gpr_rs2_data, o_gpr_rs1_busy, o_gpr_rs2_busy, o_gpr_busy_cnt
  );
endinterface

// File: rtl/gpr_file.sv
// gpr_file: integer register file with two combinational read ports, one write port
// and a per-register busy scoreboard with a registered popcount.
module gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5,
  parameter int BYPASS_EN  = 1
) (
  input logic        i_clk,
  input logic        i_rst_n,
  gpr_file_if.slave  bus
);
  localparam int N = 2**GPRS_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [N];
  logic [N-1:0]          busy_q, busy_d;
  logic [GPRS_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_ok;
  assign wr_ok = bus.i_wbu_gpr_wr_en && (bus.i_wbu_gpr_wr_id != '0);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) regs_q[k] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.i_wbu_gpr_wr_id] <= bus.i_wbu_gpr_wr_data;
    end
  // Set is applied after clear so a same-id set wins; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[bus.i_wbu_gpr_wr_id] = 1'b0;
    if (bus.i_idu_busy_set_en && bus.i_idu_busy_set_id != '0) busy_d[bus.i_idu_busy_set_id] = 1'b1;
    if (bus.i_flush) busy_d = '0;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int k = 0; k < N; k++) cnt_d = cnt_d + (GPRS_WIDTH+1)'(busy_d[k]);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  assign bus.o_gpr_rs1_data = (bus.i_idu_rs1_id == '0) ? '0 :
                              (BYPASS_EN != 0 && wr_ok && bus.i_wbu_gpr_wr_id == bus.i_idu_rs1_id) ?
                              bus.i_wbu_gpr_wr_data : regs_q[bus.i_idu_rs1_id];
  assign bus.o_gpr_rs2_data = (bus.i_idu_rs2_id == '0) ? '0 :
                              (BYPASS_EN != 0 && wr_ok && bus.i_wbu_gpr_wr_id == bus.i_idu_rs2_id) ?
                              bus.i_wbu_gpr_wr_data : regs_q[bus.i_idu_rs2_id];
  assign bus.o_gpr_rs1_busy = busy_q[bus.i_idu_rs1_id];
  assign bus.o_gpr_rs2_busy = busy_q[bus.i_idu_rs2_id];
  assign bus.o_gpr_busy_cnt = cnt_q;
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed scenarios plus randomized traffic against an array-based reference model.
module tb_gpr_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gpr_file_if #(.DATA_WIDTH(32), .GPRS_WIDTH(5)) bus();
  gpr_file #(.DATA_WIDTH(32), .GPRS_WIDTH(5), .BYPASS_EN(1)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  function automatic logic [31:0] exp_rd(logic [4:0] id);
    if (id == 0) return 32'h0;
    if (bus.i_wbu_gpr_wr_en && bus.i_wbu_gpr_wr_id == id) return bus.i_wbu_gpr_wr_data;
    return m_reg[id];
  endfunction
  function automatic logic [5:0] exp_cnt();
    int c = 0;
    foreach (m_busy[k]) c += int'(m_busy[k]);
    return 6'(c);
  endfunction
  task automatic model_reset();
    foreach (m_reg[k]) begin
      m_reg[k] = '0;
      m_busy[k] = 0;
    end
  endtask
  task automatic idle();
    bus.i_wbu_gpr_wr_en = 0; bus.i_wbu_gpr_wr_id = 0; bus.i_wbu_gpr_wr_data = 0;
    bus.i_idu_rs1_id = 0; bus.i_idu_rs2_id = 0;
    bus.i_idu_busy_set_en = 0; bus.i_idu_busy_set_id = 0; bus.i_flush = 0;
  endtask
  // Advance the model with the inputs present before the edge, then step one clock.
  task automatic tick();
    if (rst_n) begin
      if (bus.i_wbu_gpr_wr_en && bus.i_wbu_gpr_wr_id != 0) m_reg[bus.i_wbu_gpr_wr_id] = bus.i_wbu_gpr_wr_data;
      if (bus.i_flush) foreach (m_busy[k]) m_busy[k] = 0;
      else begin
        if (bus.i_wbu_gpr_wr_en && bus.i_wbu_gpr_wr_id != 0) m_busy[bus.i_wbu_gpr_wr_id] = 0;
        if (bus.i_idu_busy_set_en && bus.i_idu_busy_set_id != 0) m_busy[bus.i_idu_busy_set_id] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic write(logic [4:0] id, logic [31:0] d);
    bus.i_wbu_gpr_wr_en = 1; bus.i_wbu_gpr_wr_id = id; bus.i_wbu_gpr_wr_data = d;
  endtask
  task automatic test_reset();
    idle();
    model_reset();
    #12;
    for (int i = 0; i < 32; i++) begin
      bus.i_idu_rs1_id = 5'(i); bus.i_idu_rs2_id = 5'(31 - i);
      #1;
      n_cmp++;
      if (bus.o_gpr_rs1_data !== 32'h0 || bus.o_gpr_rs2_data !== 32'h0) begin
        n_bad++; $display("FAIL reset_read x%0d: got %h/%h want 0", i, bus.o_gpr_rs1_data, bus.o_gpr_rs2_data);
      end
    end
    n_cmp++;
    if (bus.o_gpr_busy_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.o_gpr_busy_cnt); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_bypass();
    idle(); write(5, 32'hDEADBEEF); bus.i_idu_rs1_id = 5;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass: got %h want deadbeef", bus.o_gpr_rs1_data); end
    tick();
    idle(); bus.i_idu_rs2_id = 5;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs2_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_x5: got %h want deadbeef", bus.o_gpr_rs2_data); end
  endtask
  task automatic test_x0();
    idle(); write(0, 32'h1234); bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 0;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_bypass: got %h want 0", bus.o_gpr_rs1_data); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'h0 || bus.o_gpr_rs1_busy !== 1'b0) begin
      n_bad++; $display("FAIL x0_write: got %h busy %b want 0/0", bus.o_gpr_rs1_data, bus.o_gpr_rs1_busy);
    end
    n_cmp++;
    if (bus.o_gpr_busy_cnt !== 6'd0) begin n_bad++; $display("FAIL x0_cnt: got %0d want 0", bus.o_gpr_busy_cnt); end
  endtask
  task automatic test_set_clear_same();
    idle(); bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 7;
    tick();
    idle(); bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 7; write(7, 32'h0000_0777);
    tick();
    idle(); bus.i_idu_rs1_id = 7;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_busy !== 1'b1) begin n_bad++; $display("FAIL set_wins_busy: got %b want 1", bus.o_gpr_rs1_busy); end
    n_cmp++;
    if (bus.o_gpr_busy_cnt !== 6'd1) begin n_bad++; $display("FAIL set_wins_cnt: got %0d want 1", bus.o_gpr_busy_cnt); end
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'h0000_0777) begin n_bad++; $display("FAIL set_wins_data: got %h want 777", bus.o_gpr_rs1_data); end
    write(7, 32'h1); tick(); idle();
  endtask
  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      idle(); bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 5'(i);
      tick();
    end
    idle(); bus.i_idu_rs1_id = 2; bus.i_idu_rs2_id = 3;
    #1;
    n_cmp++;
    if (bus.o_gpr_busy_cnt !== 6'd3 || bus.o_gpr_rs1_busy !== 1'b1 || bus.o_gpr_rs2_busy !== 1'b1) begin
      n_bad++; $display("FAIL three_set: cnt %0d busy %b%b want 3 11", bus.o_gpr_busy_cnt, bus.o_gpr_rs1_busy, bus.o_gpr_rs2_busy);
    end
    bus.i_flush = 1; bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 4; write(12, 32'hC0FFEE12);
    tick();
    idle(); bus.i_idu_rs1_id = 4; bus.i_idu_rs2_id = 12;
    #1;
    n_cmp++;
    if (bus.o_gpr_busy_cnt !== 6'd0 || bus.o_gpr_rs1_busy !== 1'b0) begin
      n_bad++; $display("FAIL flush: cnt %0d busy4 %b want 0 0", bus.o_gpr_busy_cnt, bus.o_gpr_rs1_busy);
    end
    n_cmp++;
    if (bus.o_gpr_rs2_data !== 32'hC0FFEE12) begin n_bad++; $display("FAIL flush_write: got %h want c0ffee12", bus.o_gpr_rs2_data); end
  endtask
  task automatic test_async_reset();
    idle(); write(9, 32'hA5A5A5A5); bus.i_idu_busy_set_en = 1; bus.i_idu_busy_set_id = 10;
    tick();
    idle(); bus.i_idu_rs1_id = 9; bus.i_idu_rs2_id = 10;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL x9_before: got %h want a5a5a5a5", bus.o_gpr_rs1_data); end
    #1 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'h0 || bus.o_gpr_rs2_busy !== 1'b0 || bus.o_gpr_busy_cnt !== 6'd0) begin
      n_bad++; $display("FAIL async_reset: data %h busy %b cnt %0d want 0", bus.o_gpr_rs1_data, bus.o_gpr_rs2_busy, bus.o_gpr_busy_cnt);
    end
    write(9, 32'h5555AAAA);
    tick();
    idle(); bus.i_idu_rs1_id = 9;
    rst_n = 1;
    #1;
    n_cmp++;
    if (bus.o_gpr_rs1_data !== 32'h0) begin n_bad++; $display("FAIL reset_discard: got %h want 0", bus.o_gpr_rs1_data); end
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] pick [4];
      foreach (pick[k]) pick[k] = 5'($urandom_range(0, 31));
      bus.i_wbu_gpr_wr_en = $urandom_range(0, 1) == 1;
      bus.i_wbu_gpr_wr_id = pick[0];
      bus.i_wbu_gpr_wr_data = $urandom;
      bus.i_idu_busy_set_en = $urandom_range(0, 2) != 0;
      bus.i_idu_busy_set_id = ($urandom_range(0, 3) == 0) ? pick[0] : pick[1];
      bus.i_idu_rs1_id = ($urandom_range(0, 3) == 0) ? pick[0] : pick[2];
      bus.i_idu_rs2_id = ($urandom_range(0, 3) == 0) ? pick[0] : pick[3];
      bus.i_flush = $urandom_range(0, 15) == 0;
      #1;
      n_cmp++;
      if (bus.o_gpr_rs1_data !== exp_rd(bus.i_idu_rs1_id) || bus.o_gpr_rs2_data !== exp_rd(bus.i_idu_rs2_id)) begin
        n_bad++; $display("FAIL rnd_read c%0d: got %h/%h want %h/%h", c, bus.o_gpr_rs1_data, bus.o_gpr_rs2_data,
                          exp_rd(bus.i_idu_rs1_id), exp_rd(bus.i_idu_rs2_id));
      end
      n_cmp++;
      if (bus.o_gpr_rs1_busy !== m_busy[bus.i_idu_rs1_id] || bus.o_gpr_rs2_busy !== m_busy[bus.i_idu_rs2_id]
          || bus.o_gpr_busy_cnt !== exp_cnt()) begin
        n_bad++; $display("FAIL rnd_busy c%0d: got %b%b cnt %0d want %b%b cnt %0d", c, bus.o_gpr_rs1_busy, bus.o_gpr_rs2_busy,
                          bus.o_gpr_busy_cnt, m_busy[bus.i_idu_rs1_id], m_busy[bus.i_idu_rs2_id], exp_cnt());
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_set_clear_same();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
